mem_req_queue: RTL
==================

Name: mem_req_queue

Overview:
- Sits directly downstream of the 2-port cache-refill crossbar.
- Buffers merged memory requests (rw, addr, tag) in a small FIFO before the memory controller port.
- Limits the number of in-flight refill reads, and counts multi-beat refill responses so the crossbar and the caches see a per-line completion strobe.

Parameters:
- ADDR_BITS, 28, request address width.
- TAG_BITS, 5, request/response tag width; the MSB is the crossbar's source-select bit, passed through untouched.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- MAX_OUT, 4, maximum outstanding reads; range 1..15.
- BEATS, 4, response beats per refill line; power of 2, at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets all state.
- in_req_val  in  1  request from crossbar valid.
- in_req_rdy  out  1  queue can accept a request.
- in_req_rw  in  1  1=write, 0=read.
- in_req_addr  in  ADDR_BITS  request address.
- in_req_tag  in  TAG_BITS  request tag.
- out_req_val  out  1  head request presented to memory.
- out_req_rdy  in  1  memory accepts the head request.
- out_req_rw  out  1  head rw.
- out_req_addr  out  ADDR_BITS  head address.
- out_req_tag  out  TAG_BITS  head tag.
- mem_resp_val  in  1  response beat valid.
- mem_resp_tag  in  TAG_BITS  response beat tag.
- resp_val  out  1  response beat toward the crossbar.
- resp_tag  out  TAG_BITS  response tag toward the crossbar.
- resp_last  out  1  this beat completes a line.
- reads_out  out  4  current outstanding-read count.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (reset==0 at clk edge):
  - FIFO count, read/write pointers, reads_out, beat counter and err all go to 0.
  - Consequently out_req_val=0 and in_req_rdy=1 from the first cycle after reset.
  - Asserting reset mid-operation discards all queued and in-flight bookkeeping; there is no drain.
- Enqueue:
  - Fires when in_req_val & in_req_rdy.
  - in_req_rdy = (count != DEPTH), taken from registered count only; no same-cycle dequeue bypass. A full queue stalls even if the head leaves that cycle.
  - Entry is written at wptr; wptr increments modulo DEPTH.
- Dispatch:
  - out_req_* are driven combinationally from the entry at rptr.
  - out_req_val = (count != 0) & (head.rw | (reads_out < MAX_OUT)).
  - Writes never wait on the read limit and never count as outstanding; there is no write response.
  - Dequeue fires when out_req_val & out_req_rdy; rptr increments modulo DEPTH.
  - Requests leave in strict FIFO order. A blocked read head also blocks the writes behind it.
  - Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Outstanding count:
  - +1 when a read dequeues.
  - -1 on a response beat with resp_last.
  - Both in the same cycle: net unchanged.
  - A last beat with reads_out==0 holds reads_out at 0 and sets err.
- Responses:
  - resp_val = mem_resp_val and resp_tag = mem_resp_tag, both combinational; zero latency.
  - Beat counter width is log2(BEATS). It increments on every mem_resp_val and wraps from BEATS-1 to 0.
  - resp_last = mem_resp_val & (beat == BEATS-1). For BEATS==1, resp_last = mem_resp_val.
  - Responses of different lines are never interleaved by memory.
  - The tag is held constant across the beats of one line. A beat whose tag differs from the first beat of its line sets err; the first-beat tag is captured in a register.
- err: sticky once set; cleared only by reset.
- Widths: count has log2(DEPTH)+1 bits; pointers have log2(DEPTH) bits.

Test Plan:
- Reset then idle:
  - Hold reset=0 for 2 cycles, release.
  - Required: in_req_rdy=1, out_req_val=0, reads_out=0, err=0, resp_last=0.
- Fill and backpressure:
  - out_req_rdy=0; present 5 writes, addr 0x10..0x14.
  - Required: first 4 accepted; in_req_rdy=0 after the 4th.
  - Then raise out_req_rdy: out_req_addr sequence is 0x10,0x11,0x12,0x13, one per cycle; in_req_rdy=1 the cycle after the first dequeue.
- Read limit:
  - out_req_rdy=1, no responses; enqueue 5 reads, tags 1..5, then a write.
  - Required: 4 reads dispatched; reads_out=4; out_req_val=0 with a read head (tag 5) while the write waits behind it.
  - After 4 response beats of tag 1 (resp_last on the 4th): reads_out=3; tag 5 dispatches next cycle, then the write.
- Beat counting:
  - 8 consecutive beats, tags 0x10 x4 then 0x02 x4.
  - Required: resp_val high all 8 cycles; resp_last high only on beats 4 and 8; resp_tag mirrors the input.
- Simultaneous events:
  - Same cycle: read dispatch with reads_out=2, last response beat, and an enqueue with count=2.
  - Required: next cycle reads_out=2, count=2.
- Error paths:
  - Last beat with reads_out=0: err=1, reads_out stays 0.
  - Separately, a tag change mid-line (beat 2 tag differs from beat 1): err=1.
  - In both cases err stays 1 until reset=0.

Source files
------------

// File: rtl/mem_req_queue.sv
// Memory request queue: FIFO toward the memory controller with an outstanding-read limit,
// plus refill response beat counting, per-line completion strobe and sticky protocol error.
module mem_req_queue #(
   parameter int ADDR_BITS = 28,
   parameter int TAG_BITS  = 5,
   parameter int DEPTH     = 4,
   parameter int MAX_OUT   = 4,
   parameter int BEATS     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_req_val,
   output logic                 in_req_rdy,
   input  logic                 in_req_rw,
   input  logic [ADDR_BITS-1:0] in_req_addr,
   input  logic [TAG_BITS-1:0]  in_req_tag,
   output logic                 out_req_val,
   input  logic                 out_req_rdy,
   output logic                 out_req_rw,
   output logic [ADDR_BITS-1:0] out_req_addr,
   output logic [TAG_BITS-1:0]  out_req_tag,
   input  logic                 mem_resp_val,
   input  logic [TAG_BITS-1:0]  mem_resp_tag,
   output logic                 resp_val,
   output logic [TAG_BITS-1:0]  resp_tag,
   output logic                 resp_last,
   output logic [3:0]           reads_out,
   output logic                 err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = 1 + ADDR_BITS + TAG_BITS;

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [3:0]    reads_q, reads_d;
   logic          err_q, err_d;
   logic          enq, deq, head_rw, last_beat, tag_bad;

   assign in_req_rdy = (count_q != CW'(DEPTH));
   assign {head_rw, out_req_addr, out_req_tag} = mem_q[rptr_q];
   assign out_req_rw  = head_rw;
   // Writes bypass the read limit, but a blocked read head still holds everything behind it.
   assign out_req_val = (count_q != '0) && (head_rw || (reads_q < 4'(MAX_OUT)));

   assign enq = in_req_val & in_req_rdy;
   assign deq = out_req_val & out_req_rdy;

   assign resp_val  = mem_resp_val;
   assign resp_tag  = mem_resp_tag;
   assign resp_last = last_beat;
   assign reads_out = reads_q;
   assign err       = err_q;

   generate
      if (BEATS > 1) begin : g_beats
         localparam int BW = $clog2(BEATS);
         logic [BW-1:0]       beat_q, beat_d;
         logic [TAG_BITS-1:0] ftag_q, ftag_d;

         assign last_beat = mem_resp_val && (beat_q == BW'(BEATS - 1));
         assign tag_bad   = mem_resp_val && (beat_q != '0) && (mem_resp_tag != ftag_q);

         always_comb begin
            beat_d = beat_q;
            ftag_d = ftag_q;
            if (mem_resp_val) begin
               beat_d = beat_q + BW'(1);
               if (beat_q == '0) begin
                  ftag_d = mem_resp_tag;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (!reset) begin
               beat_q <= '0;
               ftag_q <= '0;
            end else begin
               beat_q <= beat_d;
               ftag_q <= ftag_d;
            end
         end
      end else begin : g_single
         assign last_beat = mem_resp_val;
         assign tag_bad   = 1'b0;
      end
   endgenerate

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (enq) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (deq) begin
         rptr_d = rptr_q + PW'(1);
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      reads_d = reads_q + 4'(deq & ~head_rw) - 4'(last_beat & (reads_q != '0));
      err_d   = err_q | (last_beat & (reads_q == '0)) | tag_bad;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         reads_q <= '0;
         err_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         reads_q <= reads_d;
         err_q   <= err_d;
      end
   end

   // Entry storage is not reset; count gates its visibility.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[wptr_q] <= {in_req_rw, in_req_addr, in_req_tag};
      end
   end

endmodule
